// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN (lock-loss counter).
package pll_seq_pkg;

  // Width of the lock-loss counter output.
  localparam int unsigned LossCntWidth = 8;

  // Sequencer states; the encoding is visible on seq_state.
  typedef enum logic [2:0] {
    StPllReset  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StFail      = 3'd4
  } seq_state_e;

  // Width of a counter that must hold the largest of three cycle limits without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// downstream reset. Retries on lock timeout and gives up (sticky fail) after MAX_RETRIES.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN enables the saturating lock-loss counter;
// without it lock_loss_cnt is tied to zero.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  output logic                    pll_rst,
  output logic                    sys_rst,
  output logic                    pll_fail,
  output logic [2:0]              seq_state,
  output logic [LossCntWidth-1:0] lock_loss_cnt
);

  localparam int unsigned CntW   = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                             LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES) + 1;

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CntW-1:0]   RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              locked_s;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rst_q, sys_rst_d;
  logic              fail_q, fail_d;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // State, shared cycle counter and retry counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= StPllReset;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; a lock drop always wins over a completing count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      StPllReset: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStabilize;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = '0;
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RetryMax) ? StFail : StPllReset;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStabilize: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllReset;
          cnt_d   = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Decode outputs from the next state so registered outputs track state_q exactly.
  always_comb begin
    pll_rst_d = 1'b1;
    sys_rst_d = 1'b1;
    fail_d    = fail_q;
    unique case (state_d)
      StPllReset:  pll_rst_d = 1'b1;
      StWaitLock:  pll_rst_d = 1'b0;
      StStabilize: pll_rst_d = 1'b0;
      StRun: begin
        pll_rst_d = 1'b0;
        sys_rst_d = 1'b0;
      end
      StFail:      fail_d    = 1'b1;
      default:     pll_rst_d = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign pll_fail  = fail_q;
  assign seq_state = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LossCntWidth-1:0] loss_cnt_q;

  // Count lock losses seen in RUN, holding at all-ones instead of wrapping.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if ((state_q == StRun) && !locked_s && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: max cycles in WAIT_LOCK per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed lock attempts allowed before FAIL.
REQ-005 SHALL have port refclk, input, 1: sole clock, free-running 50.0 MHz reference.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1: reset to PLL, active-high.
REQ-009 SHALL have port sys_rst, output, 1: downstream ADC-logic reset, active-high.
REQ-010 SHALL have port pll_fail, output, 1: sticky retry-exhausted flag.
REQ-011 SHALL have port seq_state, output, 3: current state encoding.
REQ-012 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses in RUN.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; FSM uses only locked_s (2-cycle latency).
REQ-014 SHALL implement states PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
REQ-015 PLL_RESET: pll_rst=1, sys_rst=1; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK, cycle counter cleared.
REQ-016 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABILIZE; timeout counter reaching LOCK_TIMEOUT_CYCLES -> retry_cnt+1, then FAIL if retry_cnt+1==MAX_RETRIES else PLL_RESET.
REQ-017 STABILIZE: sys_rst=1; locked_s=0 -> WAIT_LOCK with timeout counter restarted; LOCK_STABLE_CYCLES consecutive locked_s=1 -> RUN.
REQ-018 RUN: sys_rst=0, pll_rst=0, retry_cnt cleared on entry; locked_s=0 -> PLL_RESET, lock_loss_cnt+1 saturating at 255.
REQ-019 FAIL: pll_rst=1, sys_rst=1, pll_fail=1; exited only by rst.
REQ-020 All outputs SHALL be registered; output change visible one cycle after state transition.
REQ-021 Lock drop on the same cycle as a STABILIZE completion SHALL take the drop (-> WAIT_LOCK).
REQ-022 Counters SHALL be sized $clog2(max param)+1 and never wrap.

Reset
REQ-023 On rst=1 at a refclk edge: state=PLL_RESET, pll_rst=1, sys_rst=1, pll_fail=0, lock_loss_cnt=0, retry_cnt=0, all counters 0, synchronizer flops 0.
REQ-024 rst asserted mid-operation (any state incl. FAIL) SHALL restart the full sequence from PLL_RESET.
REQ-025 sys_rst SHALL never be 0 in any cycle where state!=RUN.

Configuration
REQ-026 Macro PLL_SEQ_LOSS_CNT_EN defined: lock_loss_cnt counter implemented per REQ-018.
REQ-027 Macro PLL_SEQ_LOSS_CNT_EN undefined: no counter logic; lock_loss_cnt tied to 0; all other behaviour unchanged.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enum typedef and lock_loss_cnt width constant.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset to 0).

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-030 Normal bring-up: rst released, pll_locked=1 at cycle 10 -> pll_rst low from cycle 5, sys_rst low 2+8+1 cycles after lock, state=3.
REQ-031 Glitchy lock: pll_locked high 5 cycles, low 1, high -> STABILIZE aborted to WAIT_LOCK, sys_rst stays 1 until 8 clean cycles.
REQ-032 Timeout/fail: pll_locked held 0 -> two 32-cycle WAIT_LOCK attempts each preceded by 4-cycle PLL_RESET, then pll_fail=1, state=4, pll_rst=1 held.
REQ-033 Loss in RUN: drop pll_locked for 3 cycles -> sys_rst=1 within 3 cycles, pll_rst pulse of 4 cycles, lock_loss_cnt=1 (0 if macro undefined).
REQ-034 Reset mid-STABILIZE and in FAIL: rst pulse -> all outputs at REQ-023 values next cycle, pll_fail cleared, sequence restarts.
